ram_rd_stream: RTL
==================

# ram_rd_stream

Read-side initiator for the single-cycle-latency RAM read port (`ren`/`addr`/`data`) used by the `mm2s_*` memory interfaces. It accepts a (byte address, beat count) command, issues word reads to memory, and emits the words as an AXI-Stream with `tlast` on the final beat. It is fully backpressure-safe with no dropped or duplicated words. It sits between the controller's descriptor logic and the systolic-array input streams, replacing an AXI4 read path when memory is a local RAM.

## Interface
- `AXI_WIDTH`, 128: data word width in bits; power of two, ≥ 16.
- `AXI_ADDR_WIDTH`, 32: byte-address width.
- `LEN_WIDTH`, 16: beat-count width.
- `LSB`, `$clog2(AXI_WIDTH)-3`: derived; word-address shift; not overridden.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high in IDLE.
- `cmd_addr` in `AXI_ADDR_WIDTH`: start byte address; low `LSB` bits ignored.
- `cmd_beats` in `LEN_WIDTH`: number of words; 0 is legal.
- `ram_ren` out 1: read strobe.
- `ram_addr` out `AXI_ADDR_WIDTH-LSB`: word address.
- `ram_data` in `AXI_WIDTH`: read data, valid in the cycle after the `ram_ren` edge.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tdata` out `AXI_WIDTH`, `m_axis_tlast` out 1: output stream.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle pulse at command completion.

## Operation
- States: IDLE, RUN.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `word_addr = cmd_addr >> LSB` and `remaining = cmd_beats`.
  - If `cmd_beats`==0: pulse `done` next cycle, stay IDLE, no `ram_ren`, no stream beat.
  - Else go RUN and set `busy`=1.
- RUN, read issue: `ram_ren`=1 when `remaining`>0 and (`occ` + `inflight` < 2, or a stream handshake occurs this cycle).
  - `occ` is output-FIFO occupancy, 0..2.
  - `inflight` is 1 if `ram_ren` was high on the previous edge.
  - `ram_ren` is combinational from registered state and `m_axis_tready`.
- Each issued read: `ram_addr`=`word_addr`; then `word_addr`+1 (wraps modulo 2^(`AXI_ADDR_WIDTH`-`LSB`)) and `remaining`-1.
- Read return: the edge after a `ram_ren` edge captures `ram_data` into the 2-entry FIFO.
  - The FIFO cannot overflow by construction.
  - Overflow is an assertion failure.
- Tag: a beat counter marks the `cmd_beats`-th captured word; `m_axis_tlast`=1 only while that word is at the FIFO head.
- Completion: the handshake of the `tlast` beat returns the block to IDLE, pulses `done` for one cycle on the following cycle, and drops `busy`.
- Commands never overlap; `cmd_ready`=0 throughout RUN.
- Stream rules: AXI-Stream compliant. Once `tvalid` rises, `tvalid` and `tdata` are held until `tready`. `tvalid` is never gated by `tready`.
- Reset mid-command (asynchronous): state goes to IDLE, the FIFO is flushed, `inflight` is cleared, and the in-flight read return is discarded.

## Timing
- Reset values:
  - `ram_ren`=0, `ram_addr`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `busy`=0, `done`=0.
  - `cmd_ready`=1, since state is IDLE.
- Latency: command accepted at edge N → first `ram_ren` high in cycle N+1 → data captured at edge N+2 → `m_axis_tvalid`=1 in cycle N+2.
- Throughput: 1 beat/cycle with `tready` held high.
  - A command of B beats streams beats in cycles N+2..N+B+1.
  - `done` is high in cycle N+B+2.
- Backpressure: while `tready`=0 at most 2 words are outstanding (FIFO plus in-flight).
  - After `tready` rises, beats resume the same cycle with no bubble beyond FIFO refill.
- Single-beat command: `tlast`=1 on the first and only beat.

## Structure
- Package `ram_rd_stream_pkg`: state enum (`IDLE`, `RUN`) and the FIFO depth constant (2).
- Sub-module `skid_fifo2`: 2-entry register FIFO with `push`/`pop`/`occ`, data width `AXI_WIDTH`+1 (the +1 bit is `tlast`). Async active-low reset on `clk`/`rstn`.
- Top level holds the FSM, address and beat counters, and issue logic.

## Test plan
- `cmd_addr`=0x100, `cmd_beats`=4, `AXI_WIDTH`=128, `tready`=1 → `ram_addr` 0x10,0x11,0x12,0x13 on consecutive cycles; 4 beats matching memory, `tlast` on beat 4; `done` 6 cycles after accept.
- Same command, `tready` random 50% → identical data sequence, no duplicates/drops; `ram_ren` never high with `occ`+`inflight`=2 and no pop.
- `cmd_beats`=0 → no `ram_ren`, no `tvalid`; `done` pulses one cycle after accept; `cmd_ready` stays 1.
- `cmd_addr`=0xFFFFFFF0, `cmd_beats`=2 → `ram_addr` 0x0FFFFFFF then 0x0000000; 2 beats, `tlast` on second.
- Back-to-back commands (3 beats at 0x0, then 2 beats at 0x200) → second accepted only after first `done`; 5 beats total, two `tlast`s.
- `rstn` pulsed low mid-command with `tready`=0 → all outputs at reset values; a following command of 1 beat at 0x40 returns only word 0x4.

Source files
------------

// File: rtl/ram_rd_stream_pkg.sv
// ram_rd_stream_pkg
// Shared types and constants for the RAM read-stream initiator:
//   state_t    : command FSM states (IDLE waits for a command, RUN streams it)
//   FIFO_DEPTH : entries in the output skid FIFO
//   OCC_W      : width of the FIFO occupancy count (0..FIFO_DEPTH)
package ram_rd_stream_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int FIFO_DEPTH = 2;
   localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/ram_rd_stream_fifo.sv
// skid_fifo2
// Two-entry register FIFO holding read words (plus their tlast tag) that the
// stream consumer has not yet taken. Entry e0 is always the head.
//   clk, rstn : clock, asynchronous active-low reset
//   push, din : write din at the tail
//   pop       : drop the head (only when occ > 0)
//   dout      : head entry
//   occ       : number of valid entries, 0..2
module skid_fifo2
   import ram_rd_stream_pkg::*;
#(
   parameter int W = 129
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     dout,
   output logic [OCC_W-1:0] occ
);

   logic [W-1:0] e0, e1;

   assign dout = e0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         e0  <= '0;
         e1  <= '0;
         occ <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == '0) e0 <= din;
               else           e1 <= din;
               occ <= occ + OCC_W'(1);
            end
            2'b01: begin
               e0  <= e1;
               occ <= occ - OCC_W'(1);
            end
            2'b11: begin
               // Occupancy unchanged; the new word lands behind whatever
               // remains after the head leaves.
               if (occ == OCC_W'(1)) begin
                  e0 <= din;
               end else begin
                  e0 <= e1;
                  e1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   // The issue logic upstream bounds outstanding words to the depth, so these
   // can only fire on a design error.
   always_ff @(posedge clk) begin
      if (rstn) begin
         assert (!(push && !pop && occ == OCC_W'(FIFO_DEPTH)));
         assert (!(pop && occ == '0));
      end
   end

endmodule

// File: rtl/ram_rd_stream.sv
// ram_rd_stream
// Accepts a (byte address, beat count) command, reads consecutive words from a
// single-cycle-latency RAM port and presents them as an AXI-Stream with tlast
// on the final beat. Fully backpressure-safe.
//   clk, rstn               : clock, asynchronous active-low reset
//   cmd_valid/ready         : command handshake (ready only in IDLE)
//   cmd_addr, cmd_beats     : start byte address, number of words (0 legal)
//   ram_ren, ram_addr       : read strobe and word address to the RAM
//   ram_data                : read data, valid the cycle after the ren edge
//   m_axis_*                : output stream
//   busy                    : command in progress
//   done                    : one-cycle pulse after the last beat (or after a
//                             zero-beat command)
module ram_rd_stream
   import ram_rd_stream_pkg::*;
#(
   parameter int  AXI_WIDTH      = 128,
   parameter int  AXI_ADDR_WIDTH = 32,
   parameter int  LEN_WIDTH      = 16,
   localparam int LSB            = $clog2(AXI_WIDTH) - 3
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [LEN_WIDTH-1:0]          cmd_beats,
   output logic                          ram_ren,
   output logic [AXI_ADDR_WIDTH-LSB-1:0] ram_addr,
   input  logic [AXI_WIDTH-1:0]          ram_data,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [AXI_WIDTH-1:0]          m_axis_tdata,
   output logic                          m_axis_tlast,
   output logic                          busy,
   output logic                          done
);

   localparam int WA_W = AXI_ADDR_WIDTH - LSB;

   state_t               state;
   logic [WA_W-1:0]      word_addr;
   logic [LEN_WIDTH-1:0] remaining;
   logic                 inflight;       // RAM word arriving this cycle
   logic                 inflight_last;  // that word is the command's last
   logic [OCC_W-1:0]     occ;
   logic [AXI_WIDTH:0]   fifo_head;
   logic                 hs, fifo_push, fifo_pop;
   logic                 unused_addr_lsb;

   assign unused_addr_lsb = ^cmd_addr[LSB-1:0];

   assign cmd_ready = (state == IDLE);
   assign busy      = (state == RUN);
   assign ram_addr  = word_addr;

   // The stream head is the oldest buffered word; with the FIFO empty the
   // word returning from RAM is presented directly, which gives first data
   // one cycle after the first read. If it is not taken it is pushed into the
   // FIFO, so tdata stays stable while stalled.
   assign m_axis_tvalid = (occ != '0) || inflight;
   always_comb begin
      {m_axis_tlast, m_axis_tdata} = '0;
      if (occ != '0)    {m_axis_tlast, m_axis_tdata} = fifo_head;
      else if (inflight) {m_axis_tlast, m_axis_tdata} = {inflight_last, ram_data};
   end

   assign hs        = m_axis_tvalid && m_axis_tready;
   assign fifo_pop  = hs && (occ != '0);
   assign fifo_push = inflight && !(hs && (occ == '0));

   // Keep buffered + in-flight words within the FIFO depth; a pop this cycle
   // frees the slot the new read will need.
   assign ram_ren = (state == RUN) && (remaining != '0) &&
                    ((3'(occ) + 3'(inflight) < 3'(FIFO_DEPTH)) || hs);

   skid_fifo2 #(.W(AXI_WIDTH + 1)) u_fifo (
      .clk  (clk),
      .rstn (rstn),
      .push (fifo_push),
      .pop  (fifo_pop),
      .din  ({inflight_last, ram_data}),
      .dout (fifo_head),
      .occ  (occ)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         word_addr     <= '0;
         remaining     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         done          <= 1'b0;
      end else begin
         done     <= 1'b0;
         inflight <= ram_ren;
         if (ram_ren) begin
            inflight_last <= (remaining == LEN_WIDTH'(1));
            word_addr     <= word_addr + WA_W'(1);
            remaining     <= remaining - LEN_WIDTH'(1);
         end
         if (state == IDLE) begin
            if (cmd_valid) begin
               word_addr <= cmd_addr[AXI_ADDR_WIDTH-1:LSB];
               remaining <= cmd_beats;
               if (cmd_beats == '0) done  <= 1'b1;
               else                 state <= RUN;
            end
         end else if (hs && m_axis_tlast) begin
            state <= IDLE;
            done  <= 1'b1;
         end
      end
   end

endmodule
